mux_4_1_rr: RTL and testbench
=============================

# mux_4_1_rr

Registered 4:1 stream multiplexer with round-robin arbitration: the gathering counterpart of the 1:4 demultiplexer. Four independent valid/ready input channels are merged onto one output channel, one beat per cycle. Each output beat carries the 2-bit index of its source channel, so a downstream `demux_1_4` can route responses back using that index as `S`.

## Interface
- `W`, default 8: data width of every channel.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 4: per-channel valid; bit i belongs to channel i.
- `in_data`, input, 4*W: channel i data is `in_data[i*W +: W]`.
- `in_ready`, output, 4: per-channel ready; at most one bit high per cycle.
- `out_valid`, output, 1: output beat present.
- `out_data`, output, W: output beat data.
- `out_sel`, output, 2: source channel index of the output beat.
- `out_ready`, input, 1: downstream accepts the beat.

## Operation
- **Reset.** Asynchronous, active-low.
  - `out_valid`=0, `out_data`=0, `out_sel`=2'b00.
  - Round-robin pointer `last`=2'b11, so channel 0 has highest priority after reset.
  - `in_ready`=0 while `rst_n`=0.
- **Output register state.** The output register is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 (the beat leaves this cycle).
- **Arbitration.** When the register is free and any `in_valid` bit is high, grant one channel g.
  - Search order: `last`+1, `last`+2, `last`+3, `last` (mod 4).
  - g is the first channel in that order with `in_valid` set.
  - Combinational and evaluated every cycle; no state machine beyond the pointer.
- **Ready.** `in_ready[g]`=1 only when the register is free and g is granted; all other bits are 0.
  - `in_ready` never depends on `in_ready` itself.
  - It may depend combinationally on `in_valid` and `out_ready`.
- **Transfer.** A transfer on channel g occurs when `in_valid[g]`=1 and `in_ready[g]`=1. On the next edge:
  - `out_data` takes `in_data[g]`.
  - `out_sel` takes g.
  - `out_valid` is set to 1.
  - `last` takes g.
- **Drain.** If `out_valid`=1, `out_ready`=1 and no input is valid, `out_valid` clears. `out_data` and `out_sel` hold their last values.
- **Stall.** While `out_valid`=1 and `out_ready`=0, the output holds stable, `in_ready`=0, and `last` is unchanged.
- **Fairness.** Arbitration is per beat, with no packet locking. With all four channels continuously valid, grants rotate 0,1,2,3,0,… and each channel waits at most 3 beats.
- **Pointer.** `last` is 2 bits and wraps 3→0 naturally.

## Timing
- Latency: one cycle from input handshake to `out_valid`.
- Throughput: one beat per cycle when `out_ready` is held high, with no bubbles on simultaneous accept-and-refill.
- Combinational paths:
  - `out_ready` → `in_ready`, allowed and required for full throughput.
  - No path from `in_data` to any output.
- Reset asserted mid-stream: an in-flight output beat is discarded immediately and asynchronously. After deassertion, arbitration restarts with channel 0 priority.
- Input channels must hold `in_valid` and `in_data` stable until accepted. The block does not check this.

## Structure
- Package `mux_demux_pkg`:
  - `NCH`=4 and `SEL_W`=2.
  - Reset-pointer constant `RR_RESET_LAST`=2'b11.
  - Shared with `demux_1_4` users for the select encoding.
- Sub-module `rr_arbiter_4`:
  - Combinational.
  - Inputs: `req`[3:0], `last`[1:0], `en`.
  - Outputs: one-hot `gnt`[3:0], encoded `gnt_idx`[1:0], `gnt_any`.
  - The top level holds the pointer, the output register and the data mux.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-beat with `out_valid`=1. Outputs go to 0 immediately. After release, all inputs valid gives first grant to channel 0.
- **Single channel.** Only channel 2 valid with data 8'hA5, `out_ready`=1. Next cycle: `out_valid`=1, `out_data`=8'hA5, `out_sel`=2. Then `out_valid`=0 once `in_valid[2]` drops.
- **Full rotation.** All four channels valid, data 8'h10..8'h13, `out_ready`=1 for 8 cycles. `out_sel` sequence is 0,1,2,3,0,1,2,3, back-to-back with no bubble.
- **Sparse and wrap.** After a grant to channel 3, channels 0 and 3 are valid. Grant goes to 0, showing the pointer wraps 3→0 and skips channels 1 and 2.
- **Backpressure.** `out_ready`=0 for 5 cycles with channels 1 and 2 valid. `out_data` and `out_sel` stay stable and `in_ready`=0 throughout. On release, beats drain in order 1 then 2 with no loss or duplication.
- **Demux loopback.** Feed `out_sel` and `out_data[0]` to `demux_1_4` (`S`, `I`). Sending `in_data[k][0]`=1 on each channel k in turn makes `Y` equal one-hot bit k.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// mux_demux_pkg: shared constants for the 4:1 round-robin stream mux and its
// 1:4 demux counterpart. The select encoding (SEL_W bits, channel index) is
// common to both, so an out_sel from mux_4_1_rr can drive a demux_1_4 S input.
package mux_demux_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   // Pointer value after reset: "last granted = 3" makes channel 0 first in line.
   localparam logic [SEL_W-1:0] RR_RESET_LAST = 2'b11;

   // One-hot channel mask for a select value, as a demux would decode it.
   function automatic logic [NCH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
      logic [NCH-1:0] mask;
      mask = 4'b0001;
      return mask << sel;
   endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin arbiter.
// Ports:
//   req     [3:0] - per-channel request
//   last    [1:0] - index of the previously granted channel
//   en            - grant allowed this cycle
//   gnt     [3:0] - one-hot grant (all zero when en=0 or no request)
//   gnt_idx [1:0] - encoded grant index (0 when nothing granted)
//   gnt_any       - a grant was issued
module rr_arbiter_4
   import mux_demux_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] last,
   input  logic             en,
   output logic [NCH-1:0]   gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [SEL_W-1:0] cand;
   logic             hit;

   // Scan last+1, last+2, last+3, last (2-bit wrap); the first requester wins.
   always_comb begin
      gnt     = 4'b0000;
      gnt_idx = 2'b00;
      gnt_any = 1'b0;
      cand    = last;
      hit     = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         cand      = last + SEL_W'(k);
         hit       = en & ~gnt_any & req[cand];
         gnt[cand] = gnt[cand] | hit;
         gnt_idx   = hit ? cand : gnt_idx;
         gnt_any   = gnt_any | hit;
      end
   end

endmodule

// File: rtl/mux_4_1_rr.sv
// mux_4_1_rr: registered 4:1 valid/ready stream multiplexer with per-beat
// round-robin arbitration. Each output beat is tagged with its source index.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid  [3:0]       - per-channel valid
//   in_data   [4*W-1:0]   - channel i data at in_data[i*W +: W]
//   in_ready  [3:0]       - per-channel ready (at most one bit set)
//   out_valid, out_data   - registered output beat
//   out_sel   [1:0]       - registered source channel of the output beat
//   out_ready             - downstream accepts the beat
module mux_4_1_rr
   import mux_demux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     in_valid,
   input  logic [NCH*W-1:0]   in_data,
   output logic [NCH-1:0]     in_ready,
   output logic               out_valid,
   output logic [W-1:0]       out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   logic             reg_free;
   logic             arb_en;
   logic [NCH-1:0]   gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic [W-1:0]     gnt_data;

   logic             out_valid_d, out_valid_q;
   logic [W-1:0]     out_data_d,  out_data_q;
   logic [SEL_W-1:0] out_sel_d,   out_sel_q;
   logic [SEL_W-1:0] last_d,      last_q;

   // The output register can take a new beat when empty or emptying this cycle.
   // rst_n gates the arbiter so no handshake is offered while in reset.
   assign reg_free = ~out_valid_q | out_ready;
   assign arb_en   = reg_free & rst_n;

   rr_arbiter_4 u_arb (
      .req     (in_valid),
      .last    (last_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // A grant is only issued to a valid channel, so grant == ready == transfer.
   assign in_ready = gnt;

   // One-hot AND-OR data select driven by the grant vector.
   always_comb begin
      gnt_data = {W{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         gnt_data = gnt_data | (in_data[i*W +: W] & {W{gnt[i]}});
      end
   end

   // Next state: load on transfer, drop valid when drained, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      last_d      = last_q;
      if (gnt_any) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_sel_d   = gnt_idx;
         last_d      = gnt_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {W{1'b0}};
         out_sel_q   <= 2'b00;
         last_q      <= RR_RESET_LAST;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         last_q      <= last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4_1_rr.sv
// tb_mux_4_1_rr: scoreboard bench for mux_4_1_rr. Each channel is a small
// source FIFO that holds valid/data until accepted; expected output beats are
// queued when a scenario is set up and popped as beats leave the DUT.
module tb_mux_4_1_rr;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] data;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;

   int chk_cnt = 0;
   int err_cnt = 0;
   int beats_seen = 0;
   logic stall_chk = 1'b0;
   logic loop_chk  = 1'b0;

   beat_t      exp_q[$];
   logic [7:0] src_mem [4][8];
   int         src_rd  [4];
   int         src_wr  [4];

   mux_4_1_rr #(.W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Demux_1_4 behaviour: route I to output S.
   function automatic logic [3:0] demux_y(input logic [1:0] s, input logic i);
      logic [3:0] y;
      y = 4'b0000;
      y[s] = i;
      return y;
   endfunction

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = (src_rd[i] < src_wr[i]);
         in_data[i*8 +: 8] = in_valid[i] ? src_mem[i][src_rd[i]] : 8'h00;
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < 4; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end
   endtask

   task automatic push_src(input int ch, input logic [7:0] d);
      src_mem[ch][src_wr[ch]] = d;
      src_wr[ch] = src_wr[ch] + 1;
   endtask

   task automatic expect_beat(input logic [1:0] s, input logic [7:0] d);
      beat_t b;
      b.sel  = s;
      b.data = d;
      exp_q.push_back(b);
   endtask

   // One clock: sample at negedge, advance sources after the posedge.
   task automatic step();
      logic [3:0] hs;
      logic [3:0] one;
      beat_t      e;
      @(negedge clk);
      hs = in_valid & in_ready;
      if (stall_chk) begin
         check_val("stall_in_ready", in_ready, 4'b0000);
         check_val("stall_valid", out_valid, 1'b1);
         check_val("stall_data", out_data, 8'hB1);
         check_val("stall_sel", out_sel, 2'd1);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("out_sel", out_sel, e.sel);
            check_val("out_data", out_data, e.data);
            beats_seen++;
            if (loop_chk) begin
               one = 4'b0001;
               one = one << e.sel;
               check_val("demux_y", demux_y(out_sel, out_data[0]), one);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) src_rd[i] = src_rd[i] + 1;
      end
      drive();
   endtask

   initial begin
      logic [7:0] d;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 4'b0000;
      in_data   = 32'h0;
      clear_src();
      drive();
      #3;
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_data", out_data, 8'h00);
      check_val("rst_sel", out_sel, 2'b00);

      // Full rotation, loaded while still in reset: first grant must be ch0.
      for (int rep = 0; rep < 2; rep++) begin
         for (int c = 0; c < 4; c++) begin
            d = 8'h10 + 8'(c);
            push_src(c, d);
            expect_beat(2'(c), d);
         end
      end
      drive();
      #1;
      check_val("rst_in_ready", in_ready, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      beats_seen = 0;
      repeat (9) step();
      check_val("rot_beats", beats_seen, 8);

      // Sparse and wrap: last=3, channels 0 and 3 valid.
      clear_src();
      push_src(0, 8'h20);
      push_src(3, 8'h23);
      expect_beat(2'd0, 8'h20);
      expect_beat(2'd3, 8'h23);
      drive();
      beats_seen = 0;
      repeat (4) step();
      check_val("wrap_beats", beats_seen, 2);

      // Single channel 2.
      clear_src();
      push_src(2, 8'hA5);
      expect_beat(2'd2, 8'hA5);
      drive();
      beats_seen = 0;
      repeat (3) step();
      check_val("single_beats", beats_seen, 1);
      @(negedge clk);
      check_val("single_drain", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // Backpressure with channels 1 and 2 valid (last=2, so ch1 first).
      clear_src();
      out_ready = 1'b0;
      push_src(1, 8'hB1);
      push_src(2, 8'hB2);
      expect_beat(2'd1, 8'hB1);
      expect_beat(2'd2, 8'hB2);
      drive();
      beats_seen = 0;
      step();
      stall_chk = 1'b1;
      repeat (5) step();
      stall_chk = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      check_val("bp_beats", beats_seen, 2);

      // Demux loopback: bit0 set on each channel in turn.
      loop_chk = 1'b1;
      for (int k = 0; k < 4; k++) begin
         clear_src();
         push_src(k, 8'h01);
         expect_beat(2'(k), 8'h01);
         drive();
         repeat (3) step();
      end
      loop_chk = 1'b0;

      // Reset asserted with a beat in flight (last=3, ch0 granted first).
      clear_src();
      for (int c = 0; c < 4; c++) begin
         d = 8'h40 + 8'(c);
         push_src(c, d);
      end
      drive();
      step();
      check_val("pre_rst_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", out_valid, 1'b0);
      check_val("mid_rst_data", out_data, 8'h00);
      check_val("mid_rst_sel", out_sel, 2'b00);
      check_val("mid_rst_ready", in_ready, 4'b0000);
      exp_q.delete();
      push_src(0, 8'h50);
      expect_beat(2'd0, 8'h50);
      expect_beat(2'd1, 8'h41);
      expect_beat(2'd2, 8'h42);
      expect_beat(2'd3, 8'h43);
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      beats_seen = 0;
      repeat (5) step();
      check_val("post_rst_beats", beats_seen, 4);
      check_val("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
